// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch (I)
// and data load/store (D). One transaction at a time, D-priority with a
// starvation limit that forces an I grant after STARVE_LIMIT consecutive D
// grants while I waits.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                fetch request and address (held until if_ack)
//   if_ack/if_rdata               fetch completion pulse and read data
//   d_req/d_addr/d_we/d_wdata     data request payload (held until d_ack)
//   d_ack/d_rdata                 data completion pulse and read data
//   mem_req/mem_addr/mem_we/mem_wdata  registered memory request
//   mem_ack/mem_rdata             memory completion and read data
//   busy                          high while a transaction is in flight or acking
//   grant_d                       owner of current/most recent grant (1 = D)
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_d
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_d_q, grant_d_d;
  logic              busy_q, busy_d;
  logic              pick_d;

  // Next-state, arbitration and output-register logic.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d_d   = grant_d_q;
    busy_d      = busy_q;
    pick_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          // D wins unless I is waiting and has hit the starvation limit.
          pick_d      = d_req && !(if_req && (starve_q == LIMIT));
          grant_d_d   = pick_d;
          mem_addr_d  = pick_d ? d_addr : if_addr;
          mem_we_d    = pick_d & d_we;
          mem_wdata_d = pick_d ? d_wdata : '0;
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_BUSY;
          if (!pick_d) begin
            starve_d = '0;
          end else if (if_req && (starve_q != LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          if (grant_d_q) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        // Ack drops here; IDLE samples requests no earlier than the next edge.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      grant_d_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      grant_d_q   <= grant_d_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign grant_d   = grant_d_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch read, delayed data write, starvation
// grant pattern, simultaneous requests, reset mid-transaction, spurious
// mem_ack, and a request dropped before its ack.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req = 1'b0;
  logic [15:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [15:0] d_wdata = '0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic        grant_d;

  int vectors = 0;
  int errors  = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just after a grant edge; completes with a zero-wait
  // memory and ends at the negedge following the next possible grant edge.
  task automatic serve(input string tag, input logic exp_d, input logic [15:0] exp_addr,
                       input logic exp_we, input logic [15:0] rd,
                       input logic drop_i, input logic drop_d);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd1);
    check({tag, "_grant_d"}, 32'(grant_d), 32'(exp_d));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    check({tag, "_mem_we"}, 32'(mem_we), 32'(exp_we));
    mem_ack = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    check({tag, "_if_ack"}, 32'(if_ack), 32'(!exp_d));
    check({tag, "_d_ack"}, 32'(d_ack), 32'(exp_d));
    check({tag, "_rdata"}, 32'(exp_d ? d_rdata : if_rdata), 32'(rd));
    mem_ack = 1'b0;
    if (drop_i) if_req = 1'b0;
    if (drop_d) d_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_low"}, 32'({if_ack, d_ack}), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_outs", 32'({if_ack, d_ack, mem_req, mem_we, busy, grant_d}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fetch read
    if_req = 1'b1; if_addr = 16'h0004;
    @(negedge clk);
    check("fr_mem_req", 32'(mem_req), 32'd1);
    check("fr_mem_addr", 32'(mem_addr), 32'h0004);
    check("fr_mem_we", 32'(mem_we), 32'd0);
    check("fr_busy", 32'(busy), 32'd1);
    check("fr_grant_d", 32'(grant_d), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h1301;
    @(negedge clk);
    check("fr_if_ack", 32'(if_ack), 32'd1);
    check("fr_if_rdata", 32'(if_rdata), 32'h1301);
    check("fr_d_ack", 32'(d_ack), 32'd0);
    check("fr_mem_req_low", 32'(mem_req), 32'd0);
    check("fr_busy_resp", 32'(busy), 32'd1);
    mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("fr_if_ack_low", 32'(if_ack), 32'd0);
    check("fr_busy_idle", 32'(busy), 32'd0);

    // Data write with 5 wait cycles: mem_req high for 6 cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("dw_mem_req", 32'(mem_req), 32'd1);
      check("dw_mem_addr", 32'(mem_addr), 32'h0010);
      check("dw_mem_we", 32'(mem_we), 32'd1);
      check("dw_mem_wdata", 32'(mem_wdata), 32'hBEEF);
      check("dw_no_ack", 32'({if_ack, d_ack}), 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = 16'h0000;
    @(negedge clk);
    check("dw_d_ack", 32'(d_ack), 32'd1);
    check("dw_if_ack", 32'(if_ack), 32'd0);
    check("dw_mem_req_low", 32'(mem_req), 32'd0);
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("dw_d_ack_low", 32'(d_ack), 32'd0);
    check("if_rdata_hold", 32'(if_rdata), 32'h1301);

    // Starvation: both held, grants D,D,D,I,D,D,D,I
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_addr = 16'h0200;
    @(negedge clk);
    serve("st1_D", 1'b1, 16'h0200, 1'b0, 16'hA001, 1'b0, 1'b0);
    serve("st2_D", 1'b1, 16'h0200, 1'b0, 16'hA002, 1'b0, 1'b0);
    serve("st3_D", 1'b1, 16'h0200, 1'b0, 16'hA003, 1'b0, 1'b0);
    serve("st4_I", 1'b0, 16'h0100, 1'b0, 16'hA004, 1'b0, 1'b0);
    serve("st5_D", 1'b1, 16'h0200, 1'b0, 16'hA005, 1'b0, 1'b0);
    serve("st6_D", 1'b1, 16'h0200, 1'b0, 16'hA006, 1'b0, 1'b0);
    serve("st7_D", 1'b1, 16'h0200, 1'b0, 16'hA007, 1'b0, 1'b0);
    serve("st8_I", 1'b0, 16'h0100, 1'b0, 16'hA008, 1'b1, 1'b1);
    check("st_idle_after", 32'(mem_req), 32'd0);

    // Simultaneous requests with starve_cnt=0: D first, then I, each once
    if_req = 1'b1; if_addr = 16'h0300;
    d_req = 1'b1; d_addr = 16'h0400;
    @(negedge clk);
    serve("sim_D", 1'b1, 16'h0400, 1'b0, 16'hB001, 1'b0, 1'b1);
    serve("sim_I", 1'b0, 16'h0300, 1'b0, 16'hB002, 1'b1, 1'b0);
    check("sim_no_reserve", 32'({mem_req, busy}), 32'd0);
    check("sim_d_rdata_hold", 32'(d_rdata), 32'hB001);

    // Reset mid-transaction
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h1234;
    @(negedge clk);
    check("rm_busy", 32'({mem_req, busy}), 32'h3);
    #2 rst = 1'b0;
    #1;
    check("rm_async", 32'({mem_req, busy, if_ack, d_ack}), 32'd0);
    check("rm_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("rm_held", 32'({mem_req, d_ack}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    serve("rm_restart", 1'b1, 16'h0030, 1'b1, 16'h5555, 1'b0, 1'b1);
    d_we = 1'b0;

    // Spurious mem_ack in IDLE with no request
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("sp_no_ack", 32'({if_ack, d_ack}), 32'd0);
    check("sp_idle", 32'({mem_req, busy}), 32'd0);
    mem_ack = 1'b0;
    if_req = 1'b1; if_addr = 16'h0050;
    @(negedge clk);
    serve("sp_next", 1'b0, 16'h0050, 1'b0, 16'h7777, 1'b1, 1'b0);

    // Request dropped before ack still completes once
    if_req = 1'b1; if_addr = 16'h0060;
    @(negedge clk);
    check("dr_mem_req", 32'(mem_req), 32'd1);
    if_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h0A0A;
    @(negedge clk);
    check("dr_if_ack", 32'(if_ack), 32'd1);
    check("dr_if_rdata", 32'(if_rdata), 32'h0A0A);
    mem_ack = 1'b0;
    @(negedge clk);
    check("dr_ack_low", 32'(if_ack), 32'd0);
    @(negedge clk);
    check("dr_no_reserve", 32'({mem_req, busy}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
